// File: rtl/apx_iter_divider_pkg.sv
// Shared definitions for the iterative restoring divider: FSM encoding,
// default widths and the step-counter width helper.
package apx_iter_divider_pkg;

  localparam int unsigned DEF_WIDTH    = 32;
  localparam int unsigned DEF_APX_BITS = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIN  = 2'd2
  } div_state_e;

  // Bits needed to count 0..w inclusive.
  function automatic int unsigned cnt_width(input int unsigned w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/apx_iter_divider_div_step.sv
// One radix-2 restoring step: shift in the next dividend bit, compare
// against the divisor and subtract when it fits.
module apx_iter_divider_div_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_p,
  input  logic             i_a_bit,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_p,
  output logic             o_q
);

  logic [WIDTH:0]   w_shift;
  logic [WIDTH-1:0] w_diff;

  // The shifted remainder is one bit wider so the compare never overflows;
  // when it fits, the true difference is below the divisor so the low bits suffice.
  assign w_shift = {i_p, i_a_bit};
  assign w_diff  = w_shift[WIDTH-1:0] - i_d;
  assign o_q     = (w_shift >= {1'b0, i_d});
  assign o_p     = o_q ? w_diff : w_shift[WIDTH-1:0];

endmodule

// File: rtl/apx_iter_divider.sv
// Iterative radix-2 restoring unsigned divider, one quotient bit per clock.
// Optional macro APX_DIV_TRUNC_EN: run only the top WIDTH-APX_BITS steps,
// zero the low quotient bits and force the remainder to zero.
module apx_iter_divider
  import apx_iter_divider_pkg::*;
#(
  parameter int unsigned WIDTH    = DEF_WIDTH,
  parameter int unsigned APX_BITS = DEF_APX_BITS
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] read_a,
  input  logic [WIDTH-1:0] read_x,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] remainder,
  output logic             div_zero
);

`ifdef APX_DIV_TRUNC_EN
  localparam bit TRUNC_EN = 1'b1;
`else
  localparam bit TRUNC_EN = 1'b0;
`endif

  localparam int unsigned TRUNC = TRUNC_EN ? APX_BITS : 0;
  localparam int unsigned STEPS = WIDTH - TRUNC;
  localparam int unsigned CNT_W = cnt_width(WIDTH);

  div_state_e       r_state;
  div_state_e       w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_d;
  logic [WIDTH-1:0] r_p;
  logic             r_dz;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_result;
  logic [WIDTH-1:0] r_remainder;
  logic             r_div_zero;
  logic [WIDTH-1:0] w_p_nxt;
  logic             w_q_bit;

  apx_iter_divider_div_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .i_p     (r_p),
    .i_a_bit (r_a[WIDTH-1]),
    .i_d     (r_d),
    .o_p     (w_p_nxt),
    .o_q     (w_q_bit)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; a zero divisor skips the iteration entirely.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_nxt = (read_x == '0) ? ST_FIN : ST_CALC;
        end
      end
      ST_CALC: begin
        if (r_cnt == CNT_W'(STEPS - 1)) begin
          w_state_nxt = ST_FIN;
        end
      end
      ST_FIN:  w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Datapath: operand capture, per-step shift/subtract, result registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt       <= '0;
      r_a         <= '0;
      r_d         <= '0;
      r_p         <= '0;
      r_dz        <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_result    <= '0;
      r_remainder <= '0;
      r_div_zero  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_busy <= (w_state_nxt == ST_CALC);
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_a         <= read_a;
            r_d         <= read_x;
            r_p         <= '0;
            r_cnt       <= '0;
            r_dz        <= (read_x == '0);
            r_result    <= '0;
            r_remainder <= '0;
            r_div_zero  <= 1'b0;
          end
        end
        ST_CALC: begin
          r_p   <= w_p_nxt;
          r_a   <= {r_a[WIDTH-2:0], w_q_bit};
          r_cnt <= r_cnt + CNT_W'(1);
        end
        ST_FIN: begin
          r_done <= 1'b1;
          if (r_dz) begin
            // Dividend is still untouched in r_a since no step ran.
            r_result    <= '1;
            r_remainder <= r_a;
            r_div_zero  <= 1'b1;
          end else begin
            // Quotient bits sit in the low STEPS bits of r_a.
            r_result    <= r_a << TRUNC;
            r_remainder <= TRUNC_EN ? '0 : r_p;
            r_div_zero  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign result    = r_result;
  assign remainder = r_remainder;
  assign div_zero  = r_div_zero;

endmodule

// File: tb/tb_apx_iter_divider.sv
// Self-checking bench for apx_iter_divider against an arithmetic reference model.
module tb_apx_iter_divider;

  localparam int unsigned W  = 32;
  localparam int unsigned AB = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [W-1:0] read_a;
  logic [W-1:0] read_x;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic [W-1:0] remainder;
  logic         div_zero;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  int unsigned n_fail   = 0;

  always #5 clk = ~clk;

  apx_iter_divider #(
    .WIDTH    (W),
    .APX_BITS (AB)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .read_a    (read_a),
    .read_x    (read_x),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .remainder (remainder),
    .div_zero  (div_zero)
  );

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Reference: quotient, remainder, clocks from accept edge to done, busy cycles.
  task automatic model(input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [W-1:0] q, output logic [W-1:0] r,
                       output int lat, output int nbusy);
    if (b == '0) begin
      q = '1; r = a; lat = 1; nbusy = 0;
    end else begin
`ifdef APX_DIV_TRUNC_EN
      q = ((a >> AB) / b) << AB; r = '0; lat = W - AB + 1; nbusy = W - AB;
`else
      q = a / b; r = a % b; lat = W + 1; nbusy = W;
`endif
    end
  endtask

  // Single operation; optionally pulses start with other operands mid-flight.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input int glitch_at, input string tag);
    logic [W-1:0] eq, er;
    int elat, ebusy, cyc, busy_n;
    bit seen;
    model(a, b, eq, er, elat, ebusy);
    @(negedge clk);
    start = 1'b1; read_a = a; read_x = b;
    @(posedge clk); #1;
    start = 1'b0; read_a = $urandom; read_x = $urandom;
    check($sformatf("%s_res_clr", tag), result, '0);
    check($sformatf("%s_dz_clr", tag), W'(div_zero), '0);
    busy_n = busy ? 1 : 0;
    cyc = 0;
    seen = 1'b0;
    while (!seen && cyc < 200) begin
      if (cyc == glitch_at) begin
        start = 1'b1; read_a = 32'd4; read_x = 32'd2;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      cyc++;
      if (done) seen = 1'b1;
      else if (busy) busy_n++;
    end
    start = 1'b0;
    check($sformatf("%s_latency", tag), W'(cyc), W'(elat));
    check($sformatf("%s_result", tag), result, eq);
    check($sformatf("%s_rem", tag), remainder, er);
    check($sformatf("%s_divzero", tag), W'(div_zero), W'(b == '0));
    check($sformatf("%s_busy_cycles", tag), W'(busy_n), W'(ebusy));
    @(posedge clk); #1;
    check($sformatf("%s_done_pulse", tag), W'(done), '0);
    check($sformatf("%s_hold", tag), result, eq);
  endtask

  initial begin
    logic [W-1:0] a1, b1, a2, b2, q1, r1, q2, r2;
    int l1, l2, nb, cyc, done_n;

    reset = 1'b1; start = 1'b0; read_a = '0; read_x = '0;
    #12;
    check("rst_busy", W'(busy), '0);
    check("rst_done", W'(done), '0);
    check("rst_result", result, '0);
    check("rst_rem", remainder, '0);
    check("rst_divzero", W'(div_zero), '0);
    @(negedge clk); reset = 1'b0;

    run_op(32'd6, 32'd3, -1, "d6_3");
    run_op(32'h0106, 32'h0048, -1, "d262_72");
    run_op(32'd15, 32'd2, -1, "d15_2");
    run_op(32'd7, 32'd0, -1, "d7_0");
    run_op(32'd9, 32'd3, -1, "d9_3");
    run_op(32'h1234_5678, 32'h10, -1, "d_trunc");
    run_op(32'd0, 32'd5, -1, "d0_5");
    run_op(32'd5, 32'd9, -1, "d5_9");
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, "dmax_max");
    run_op(32'hFFFF_FFFF, 32'd1, 10, "glitch");

    for (int i = 0; i < 10; i++) begin
      a1 = $urandom;
      case (i % 3)
        0: b1 = $urandom;
        1: b1 = W'($urandom_range(1, 1000));
        default: b1 = $urandom & 32'hFF;
      endcase
      run_op(a1, b1, -1, $sformatf("rand%0d", i));
    end

    // Reset mid-operation: abandoned, no done, outputs back to reset values.
    @(negedge clk);
    start = 1'b1; read_a = $urandom; read_x = 32'd3;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (20) @(posedge clk);
    #1 reset = 1'b1;
    #2;
    check("midrst_busy", W'(busy), '0);
    check("midrst_done", W'(done), '0);
    check("midrst_result", result, '0);
    check("midrst_rem", remainder, '0);
    check("midrst_divzero", W'(div_zero), '0);
    @(negedge clk); reset = 1'b0;
    done_n = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) done_n++;
    end
    check("midrst_no_done", W'(done_n), '0);

    // Back-to-back with start held high across two operations.
    a1 = $urandom; b1 = W'($urandom_range(1, 5000));
    a2 = $urandom; b2 = $urandom | 32'h1;
    model(a1, b1, q1, r1, l1, nb);
    model(a2, b2, q2, r2, l2, nb);
    @(negedge clk);
    start = 1'b1; read_a = a1; read_x = b1;
    @(posedge clk); #1;
    read_a = a2; read_x = b2;
    cyc = 0;
    while (!done && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("b2b_op1_latency", W'(cyc), W'(l1));
    check("b2b_op1_result", result, q1);
    check("b2b_op1_rem", remainder, r1);
    @(posedge clk); #1;
    start = 1'b0; read_a = $urandom; read_x = $urandom;
    cyc = 1;
    while (!done && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("b2b_done_spacing", W'(cyc), W'(l2 + 1));
    check("b2b_op2_result", result, q2);
    check("b2b_op2_rem", remainder, r2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
